// File: rtl/maxset_pkg.sv
// Shared definitions for the MaxSet feeder slice.
// Contents:
//   WIDTH, LANES, LANE_W, PAD_VALUE  datapath geometry and the pad value for short sets
//   feeder_state_t                   read-side FSM states
//   condition_sample()               input conditioning applied to every stored sample
// Build option:
//   FEEDER_SIGN_CLAMP_EN  when defined, samples with the MSB set are stored as zero
package maxset_pkg;

  localparam int unsigned     WIDTH     = 32;
  localparam int unsigned     LANES     = 4;
  localparam int unsigned     LANE_W    = $clog2(LANES);
  localparam logic [WIDTH-1:0] PAD_VALUE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } feeder_state_t;

  // MaxNet needs non-negative activations; a set MSB means negative for both
  // IEEE float and two's complement, so the clamp needs no format knowledge.
  function automatic logic [WIDTH-1:0] condition_sample(input logic [WIDTH-1:0] s);
`ifdef FEEDER_SIGN_CLAMP_EN
    return s[WIDTH-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

endpackage

// File: rtl/maxset_bank.sv
// One bank of the feeder ping-pong buffer: LANES x WIDTH register file.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   wr_en_i        write one sample into lane wr_lane_i
//   wr_lane_i      target lane
//   wr_data_i      sample value (already conditioned)
//   wr_last_i      final sample of a short set: lanes above wr_lane_i get PAD_VALUE
//   clr_i          release the bank (clears the full flag)
//   full_o         bank holds a complete set
//   data_o         lane i at bits [i*WIDTH +: WIDTH]
module maxset_bank
  import maxset_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [LANE_W-1:0]      wr_lane_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   wr_last_i,
  input  logic                   clr_i,
  output logic                   full_o,
  output logic [LANES*WIDTH-1:0] data_o
);

  logic full_q;
  logic set_full;

  assign set_full = wr_en_i && (wr_last_i || (wr_lane_i == LANE_W'(LANES - 1)));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] lane_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          lane_q <= '0;
        end else if (wr_en_i) begin
          if (wr_lane_i == LANE_W'(gi)) begin
            lane_q <= wr_data_i;
          end else if (wr_last_i && (int'(wr_lane_i) < gi)) begin
            lane_q <= PAD_VALUE;
          end
        end
      end

      assign data_o[gi*WIDTH +: WIDTH] = lane_q;
    end
  endgenerate

  // Set and clear never target the same bank in one cycle (a bank being
  // released is full, so it cannot be written); set wins just in case.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/maxset_feeder.sv
// Upstream stage of the MaxSet core: packs a serial sample stream into
// LANES-wide sets using two ping-pong banks, launches each set with a start
// pulse and holds x_set until done (or the watchdog) releases it.
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   in_valid/in_ready     sample handshake; in_data sample, in_last ends a short set
//   x_set                 set presented to the core, lane i = [i*WIDTH +: WIDTH]
//   start                 one-cycle pulse when x_set becomes valid
//   done                  core completion, honoured only in RUN
//   busy                  high in LAUNCH and RUN
//   timeout               sticky watchdog flag
//   set_count             number of sets launched (wraps)
// Parameter:
//   TIMEOUT               RUN cycles before a set is discarded; 0 disables
// Build option:
//   FEEDER_SIGN_CLAMP_EN  store negative samples as zero
module maxset_feeder
  import maxset_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic [LANES*WIDTH-1:0] x_set,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic                   timeout,
  output logic [15:0]            set_count
);

  localparam int unsigned        CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Write side
  logic              wr_bank_q, wr_bank_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              xfer;
  logic              set_done;
  logic [WIDTH-1:0]  sample;

  // Banks
  logic [1:0]             full;
  logic [LANES*WIDTH-1:0] bank_data [2];

  // Read side
  feeder_state_t          state_q, state_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LANES*WIDTH-1:0] x_set_q, x_set_d;
  logic                   start_q, start_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            set_count_q, set_count_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                   release_set;

  assign in_ready = ~full[wr_bank_q];
  assign xfer     = in_valid & in_ready;
  assign set_done = xfer & (in_last | (lane_q == LANE_W'(LANES - 1)));
  assign sample   = condition_sample(in_data);

  assign lane_d    = set_done ? '0 : (xfer ? lane_q + 1'b1 : lane_q);
  assign wr_bank_d = set_done ? ~wr_bank_q : wr_bank_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      maxset_bank u_bank (
        .clk_i     (clock),
        .rst_ni    (reset),
        .wr_en_i   (xfer && (wr_bank_q == 1'(gi))),
        .wr_lane_i (lane_q),
        .wr_data_i (sample),
        .wr_last_i (in_last),
        .clr_i     (release_set && (rd_bank_q == 1'(gi))),
        .full_o    (full[gi]),
        .data_o    (bank_data[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    x_set_d     = x_set_q;
    start_d     = 1'b0;
    timeout_d   = timeout_q;
    set_count_d = set_count_q;
    wd_cnt_d    = wd_cnt_q;
    release_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (full[rd_bank_q]) state_d = LAUNCH;
      end
      LAUNCH: begin
        // start is registered so it rises together with the new x_set.
        x_set_d     = bank_data[rd_bank_q];
        start_d     = 1'b1;
        set_count_d = set_count_q + 16'd1;
        wd_cnt_d    = '0;
        state_d     = RUN;
      end
      RUN: begin
        if (done) begin
          release_set = 1'b1;
        end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
          release_set = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (release_set) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_bank_q   <= 1'b0;
      lane_q      <= '0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      x_set_q     <= '0;
      start_q     <= 1'b0;
      timeout_q   <= 1'b0;
      set_count_q <= '0;
      wd_cnt_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      lane_q      <= lane_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      x_set_q     <= x_set_d;
      start_q     <= start_d;
      timeout_q   <= timeout_d;
      set_count_q <= set_count_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign x_set     = x_set_q;
  assign start     = start_q;
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;
  assign set_count = set_count_q;

endmodule

// File: tb/tb_maxset_feeder.sv
module tb_maxset_feeder;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [127:0] x_set;
  logic         start;
  logic         done;
  logic         busy;
  logic         timeout;
  logic [15:0]  set_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] xs;
    logic [15:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  maxset_feeder #(.TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .x_set     (x_set),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .timeout   (timeout),
    .set_count (set_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_set(input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] l3,
                            input logic [15:0] cnt);
    exp_t e;
    e.xs  = {l3, l2, l1, l0};
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every start pulse pops one expected set.
  always @(negedge clock) begin
    if (start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start: got start with x_set %h expected no start", x_set);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x_set", x_set, e.xs);
        check("set_count", {112'd0, set_count}, {112'd0, e.cnt});
      end
    end
  end

  // Called and returns at a negedge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_ready: got in_ready=0 for %0d cycles expected in_ready=1", n);
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (start !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL wait_start: got no start in %0d cycles expected start", n);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  {127'd0, in_ready},   128'd1);
    check({tag, "_start"},     {127'd0, start},      128'd0);
    check({tag, "_busy"},      {127'd0, busy},       128'd0);
    check({tag, "_timeout"},   {127'd0, timeout},    128'd0);
    check({tag, "_set_count"}, {112'd0, set_count},  128'd0);
    check({tag, "_x_set"},     x_set,                128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int k;
    logic [31:0] neg_exp;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    done     = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("rst");
    reset = 1'b1;
    @(negedge clock);
    check("first_edge_start", {127'd0, start}, 128'd0);

    // 1: full set, latency and ordering
    expect_set(32'd5, 32'd9, 32'd2, 32'd7, 16'd1);
    send4(32'd5, 32'd9, 32'd2, 32'd7);
    check("t1_start_n1", {127'd0, start}, 128'd0);
    @(negedge clock);
    check("t1_launch_busy", {127'd0, busy}, 128'd1);
    check("t1_start_n2", {127'd0, start}, 128'd0);
    @(negedge clock);
    check("t1_start_n3", {127'd0, start}, 128'd1);
    pulse_done();
    check("t1_idle_busy", {127'd0, busy}, 128'd0);

    // 2: second bank fills while the first is in flight, then back-pressure
    expect_set(32'd10, 32'd11, 32'd12, 32'd13, 16'd2);
    expect_set(32'd20, 32'd21, 32'd22, 32'd23, 16'd3);
    send4(32'd10, 32'd11, 32'd12, 32'd13);
    send4(32'd20, 32'd21, 32'd22, 32'd23);
    check("t2_both_full_ready", {127'd0, in_ready}, 128'd0);
    check("t2_x_set_held", x_set, {32'd13, 32'd12, 32'd11, 32'd10});
    pulse_done();
    check("t2_ready_after_free", {127'd0, in_ready}, 128'd1);
    expect_set(32'd30, 32'd31, 32'd32, 32'd33, 16'd4);
    send4(32'd30, 32'd31, 32'd32, 32'd33);
    pulse_done();
    wait_start();
    pulse_done();

    // 3: short set padded
    expect_set(32'd3, 32'd4, 32'd0, 32'd0, 16'd5);
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    wait_start();
    pulse_done();

    // 4: watchdog
    expect_set(32'd40, 32'd41, 32'd42, 32'd43, 16'd6);
    send4(32'd40, 32'd41, 32'd42, 32'd43);
    wait_start();
    k = 0;
    while (timeout !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("t4_timeout_cycle", 128'(k), 128'd16);
    check("t4_busy_after_timeout", {127'd0, busy}, 128'd0);
    expect_set(32'd50, 32'd51, 32'd52, 32'd53, 16'd7);
    send4(32'd50, 32'd51, 32'd52, 32'd53);
    wait_start();
    pulse_done();
    check("t4_timeout_sticky", {127'd0, timeout}, 128'd1);

    // 5: reset mid-fill
    send(32'd60, 1'b0);
    send(32'd61, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_first_edge_start", {127'd0, start}, 128'd0);
    expect_set(32'd70, 32'd71, 32'd72, 32'd73, 16'd1);
    send4(32'd70, 32'd71, 32'd72, 32'd73);
    wait_start();
    pulse_done();

    // 6: sign clamp option
`ifdef FEEDER_SIGN_CLAMP_EN
    neg_exp = 32'h0000_0000;
`else
    neg_exp = 32'hBF80_0000;
`endif
    expect_set(neg_exp, 32'd1, 32'd2, 32'd3, 16'd2);
    send4(32'hBF80_0000, 32'd1, 32'd2, 32'd3);
    wait_start();
    pulse_done();

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
